prog_ram_loader: RTL and testbench

Writable replacement for the switch-programmed program memory. Holds 16 x 8-bit instruction words. A byte-stream load interface fills the words in order from address 0. The CPU fetch side reads through the same address-in/data-out port as the switch ROM: 4-bit address, 8-bit instruction. The block holds the CPU in reset while a load is in progress.

---
 rtl/prog_loader_pkg.sv | 17 +
 rtl/prog_ram_16x8.sv | 35 +++
 rtl/prog_ram_loader.sv | 148 ++++++++++++++
 tb/tb_prog_ram_loader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the writable program memory loader.
// The checksum width is used only when PROG_RAM_LOADER_CHECKSUM_EN is defined.
package prog_loader_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 4;
    localparam int DEPTH  = 16;
    localparam int CSUM_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHK,
        RUN
    } state_t;

endpackage

// File: rtl/prog_ram_16x8.sv
// Register-array program memory: async clear, one sync write port,
// one combinational read port used by the CPU fetch path.
import prog_loader_pkg::*;

module prog_ram_16x8 #(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] A,
    output logic [DW-1:0] Q
);

    localparam int NWORDS = 2 ** AW;

    logic [DW-1:0] mem [NWORDS];

    // Clear every word on reset, otherwise write one word per enabled cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NWORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign Q = mem[A];

endmodule

// File: rtl/prog_ram_loader.sv
// Byte-stream loader for the program RAM; holds the CPU in reset while loading.
// Define PROG_RAM_LOADER_CHECKSUM_EN to add a trailing checksum byte check.
import prog_loader_pkg::*;

module prog_ram_loader #(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          load_start,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic [AW-1:0] A,
    output logic [DW-1:0] Q,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [AW-1:0] LAST = '1;

    state_t        state;
    logic [AW-1:0] waddr;
    logic          accept;
    logic          we;

    assign accept = wr_valid & wr_ready;
    // A restart request wins over a byte offered in the same cycle
    assign we     = accept & (state == LOAD) & ~load_start;

    prog_ram_16x8 #(
        .DW(DW),
        .AW(AW)
    ) u_ram (
        .CLK  (CLK),
        .RST  (RST),
        .we   (we),
        .waddr(waddr),
        .wdata(wr_data),
        .A    (A),
        .Q    (Q)
    );

`ifdef PROG_RAM_LOADER_CHECKSUM_EN
    logic [CSUM_W-1:0] sum;
    logic              err_r;

    assign err = err_r;

    // Load FSM with trailing checksum byte; all outputs registered
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            waddr    <= '0;
            wr_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cpu_hold <= 1'b1;
            err_r    <= 1'b0;
            sum      <= '0;
        end else begin
            done <= 1'b0;
            if (load_start) begin
                state    <= LOAD;
                waddr    <= '0;
                wr_ready <= 1'b1;
                busy     <= 1'b1;
                cpu_hold <= 1'b1;
                err_r    <= 1'b0;
                sum      <= '0;
            end else begin
                unique case (state)
                    LOAD: begin
                        if (accept) begin
                            sum <= sum + CSUM_W'(wr_data);
                            if (waddr == LAST) begin
                                state <= CHK;
                            end else begin
                                waddr <= waddr + 1'b1;
                            end
                        end
                    end
                    CHK: begin
                        if (accept) begin
                            wr_ready <= 1'b0;
                            busy     <= 1'b0;
                            if (CSUM_W'(wr_data) == sum) begin
                                state    <= RUN;
                                cpu_hold <= 1'b0;
                                done     <= 1'b1;
                            end else begin
                                state    <= IDLE;
                                cpu_hold <= 1'b1;
                                err_r    <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
`else
    assign err = 1'b0;

    // Load FSM: word 15 accepted goes straight to RUN; outputs registered
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            waddr    <= '0;
            wr_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cpu_hold <= 1'b1;
        end else begin
            done <= 1'b0;
            if (load_start) begin
                state    <= LOAD;
                waddr    <= '0;
                wr_ready <= 1'b1;
                busy     <= 1'b1;
                cpu_hold <= 1'b1;
            end else begin
                unique case (state)
                    LOAD: begin
                        if (accept) begin
                            if (waddr == LAST) begin
                                state    <= RUN;
                                wr_ready <= 1'b0;
                                busy     <= 1'b0;
                                cpu_hold <= 1'b0;
                                done     <= 1'b1;
                            end else begin
                                waddr <= waddr + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
`endif

endmodule

// File: tb/tb_prog_ram_loader.sv
// Self-checking bench for prog_ram_loader: hand tables, directed
// sequences and random traffic against a behavioural memory model.
module tb_prog_ram_loader;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       load_start = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic [3:0] A = 4'h0;
    logic [7:0] Q;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       err;

    always #5 CLK = ~CLK;

    prog_ram_loader dut (
        .CLK       (CLK),
        .RST       (RST),
        .load_start(load_start),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .A         (A),
        .Q         (Q),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Behavioural model: memory image, byte count, loading/running flags
    logic [7:0] m_mem [16];
    bit         m_load;
    bit         m_run;
    bit         m_done;
    bit         m_err;
    int         m_cnt;
    logic [7:0] m_sum;

    int n_vec = 0;
    int n_bad = 0;
    int n_done_seen = 0;

    typedef struct {
        bit         ls;
        bit         wv;
        logic [7:0] wd;
        logic [3:0] a;
        logic [7:0] q;
        bit         hold;
        bit         ready;
        bit         dn;
    } vec_t;

    vec_t tbl[$];

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_load = 0;
        m_run  = 0;
        m_done = 0;
        m_err  = 0;
        m_cnt  = 0;
        m_sum  = 8'h00;
    endfunction

    function automatic void m_clock(bit ls, bit wv, logic [7:0] wd);
        m_done = 0;
        if (ls) begin
            m_load = 1;
            m_run  = 0;
            m_cnt  = 0;
            m_sum  = 8'h00;
            m_err  = 0;
        end else if (m_load && wv) begin
            if (m_cnt < 16) begin
                m_mem[m_cnt] = wd;
                m_sum = m_sum + wd;
                m_cnt++;
`ifndef PROG_RAM_LOADER_CHECKSUM_EN
                if (m_cnt == 16) begin
                    m_load = 0;
                    m_run  = 1;
                    m_done = 1;
                end
`endif
            end else begin
                m_load = 0;
                if (wd == m_sum) begin
                    m_run  = 1;
                    m_done = 1;
                end else begin
                    m_err = 1;
                end
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit ls, input bit wv, input logic [7:0] wd, input logic [3:0] a);
        @(negedge CLK);
        load_start = ls;
        wr_valid   = wv;
        wr_data    = wd;
        A          = a;
        #1;
    endtask

    // One cycle: drive, compare all outputs with the model, clock the model
    task automatic step(input bit ls, input bit wv, input logic [7:0] wd, input logic [3:0] a);
        drive(ls, wv, wd, a);
        chk("Q", Q, m_mem[a]);
        chk("wr_ready", {7'b0, wr_ready}, {7'b0, m_load});
        chk("busy", {7'b0, busy}, {7'b0, m_load});
        chk("cpu_hold", {7'b0, cpu_hold}, {7'b0, !m_run});
        chk("done", {7'b0, done}, {7'b0, m_done});
        chk("err", {7'b0, err}, {7'b0, m_err});
        if (done) n_done_seen++;
        @(posedge CLK);
        m_clock(ls, wv, wd);
    endtask

    task automatic apply_vec(input vec_t v);
        drive(v.ls, v.wv, v.wd, v.a);
        chk("tbl_q", Q, v.q);
        chk("tbl_hold", {7'b0, cpu_hold}, {7'b0, v.hold});
        chk("tbl_ready", {7'b0, wr_ready}, {7'b0, v.ready});
        chk("tbl_done", {7'b0, done}, {7'b0, v.dn});
        @(posedge CLK);
        m_clock(v.ls, v.wv, v.wd);
    endtask

    // Reset asserted and released away from clock edges
    task automatic do_reset();
        @(negedge CLK);
        load_start = 0;
        wr_valid   = 0;
        #2;
        RST = 1'b1;
        m_reset();
        @(posedge CLK);
        #2;
        RST = 1'b0;
    endtask

    // Send the checksum byte when the model expects one (checksum build only)
    task automatic finish_load(input bit good);
`ifdef PROG_RAM_LOADER_CHECKSUM_EN
        step(0, 1, good ? m_sum : m_sum + 8'h01, 4'h0);
`else
        if (good) step(0, 0, 8'h00, 4'h0);
`endif
    endtask

    int d0;

    initial begin
        m_reset();

        for (int i = 0; i < 16; i++)
            tbl.push_back('{ls: 0, wv: 1, wd: 8'hFF, a: 4'(i), q: 8'h00,
                            hold: 1, ready: 0, dn: 0});
        tbl.push_back('{ls: 1, wv: 0, wd: 8'h00, a: 4'h0, q: 8'h00,
                        hold: 1, ready: 0, dn: 0});
        for (int i = 0; i < 16; i++)
            tbl.push_back('{ls: 0, wv: 1, wd: 8'(8'h10 + i), a: 4'(i), q: 8'h00,
                            hold: 1, ready: 1, dn: 0});
`ifdef PROG_RAM_LOADER_CHECKSUM_EN
        tbl.push_back('{ls: 0, wv: 0, wd: 8'h00, a: 4'h5, q: 8'h15,
                        hold: 1, ready: 1, dn: 0});
`else
        tbl.push_back('{ls: 0, wv: 0, wd: 8'h00, a: 4'h5, q: 8'h15,
                        hold: 0, ready: 0, dn: 1});
        tbl.push_back('{ls: 0, wv: 0, wd: 8'h00, a: 4'hF, q: 8'h1F,
                        hold: 0, ready: 0, dn: 0});
`endif

        // Reset state, memory cleared, then full 16-byte load
        do_reset();
        chk("rst_busy", {7'b0, busy}, 8'h00);
        chk("rst_err", {7'b0, err}, 8'h00);
        foreach (tbl[i]) apply_vec(tbl[i]);

        // Gapped stream: only beats with wr_valid written, no skipped words
        d0 = n_done_seen;
        step(1, 0, 8'h00, 4'h0);
        for (int k = 0; k < 32; k++)
            step(0, bit'(k % 2 == 0), 8'($urandom), 4'($urandom));
        finish_load(1);
        step(0, 0, 8'h00, 4'h0);
        for (int i = 0; i < 16; i++) step(0, 0, 8'h00, 4'(i));
        chk("gap_done_count", 8'(n_done_seen - d0), 8'd1);

        // Restart after 6 bytes, then full load of A0..AF
        d0 = n_done_seen;
        step(1, 0, 8'h00, 4'h0);
        for (int i = 0; i < 6; i++) step(0, 1, 8'(8'h50 + i), 4'h0);
        step(1, 0, 8'h00, 4'h0);
        chk("restart_no_done", 8'(n_done_seen - d0), 8'd0);
        for (int i = 0; i < 16; i++) step(0, 1, 8'(8'hA0 + i), 4'(i));
        finish_load(1);
        step(0, 0, 8'h00, 4'h0);
        drive(0, 0, 8'h00, 4'h0);
        chk("restart_mem0", Q, 8'hA0);
        chk("restart_done_count", 8'(n_done_seen - d0), 8'd1);

        // Reset after 9 bytes: memory cleared, idle, no done
        d0 = n_done_seen;
        step(1, 0, 8'h00, 4'h0);
        for (int i = 0; i < 9; i++) step(0, 1, 8'(8'hC0 + i), 4'(i));
        do_reset();
        for (int i = 0; i < 16; i++) step(0, 0, 8'h00, 4'(i));
        drive(0, 0, 8'h00, 4'h3);
        chk("midrst_q3", Q, 8'h00);
        chk("midrst_busy", {7'b0, busy}, 8'h00);
        chk("midrst_hold", {7'b0, cpu_hold}, 8'h01);
        chk("midrst_no_done", 8'(n_done_seen - d0), 8'd0);

`ifdef PROG_RAM_LOADER_CHECKSUM_EN
        // Good checksum, then bad checksum, then err cleared by load_start
        d0 = n_done_seen;
        step(1, 0, 8'h00, 4'h0);
        for (int i = 0; i < 16; i++) step(0, 1, 8'h01, 4'(i));
        step(0, 1, 8'h10, 4'h0);
        step(0, 0, 8'h00, 4'h0);
        chk("csum_ok_done", 8'(n_done_seen - d0), 8'd1);
        chk("csum_ok_err", {7'b0, err}, 8'h00);
        d0 = n_done_seen;
        step(1, 0, 8'h00, 4'h0);
        for (int i = 0; i < 16; i++) step(0, 1, 8'h01, 4'(i));
        step(0, 1, 8'h11, 4'h0);
        step(0, 0, 8'h00, 4'h0);
        chk("csum_bad_err", {7'b0, err}, 8'h01);
        chk("csum_bad_hold", {7'b0, cpu_hold}, 8'h01);
        chk("csum_bad_no_done", 8'(n_done_seen - d0), 8'd0);
        step(1, 0, 8'h00, 4'h0);
        drive(0, 0, 8'h00, 4'h0);
        chk("csum_err_clear", {7'b0, err}, 8'h00);
        @(posedge CLK);
        m_clock(0, 0, 8'h00);
`endif

        // Random traffic against the model
        for (int k = 0; k < 800; k++) begin
            bit         ls;
            bit         wv;
            logic [7:0] wd;
            ls = ($urandom_range(0, 15) == 0);
            wv = ($urandom_range(0, 3) != 0);
            wd = 8'($urandom);
            if (m_cnt == 16 && m_load && $urandom_range(0, 1) == 1) wd = m_sum;
            if ($urandom_range(0, 199) == 0) do_reset();
            step(ls, wv, wd, 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
